// File: rtl/wca_pkg.sv
// Shared constants for the weight-buffer read arbiter: arbitration modes,
// default widths and the port-id width helper.
package wca_pkg;

   localparam logic [1:0] ARB_MODE_RR    = 2'b00;
   localparam logic [1:0] ARB_MODE_FIXED = 2'b01;
   localparam logic [1:0] ARB_MODE_HOLD  = 2'b10;

   localparam int NUM_PORT_DEF       = 4;
   localparam int WEI_ADDR_WIDTH_DEF = 8;
   localparam int DATA_WIDTH_DEF     = 8;
   localparam int OUTST_DEPTH_DEF    = 4;

   // Width of a port id; never below one bit so single-port builds still elaborate.
   function automatic int id_width(input int num_port);
      return (num_port > 1) ? $clog2(num_port) : 1;
   endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order port-id FIFO: one id per outstanding WBF read, popped as data returns.
module arb_id_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_id_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_id_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o    = (cnt_q == (PTR_W+1)'(DEPTH));
   assign empty_o   = (cnt_q == '0);
   assign count_o   = cnt_q;
   assign head_id_o = mem_q[rd_ptr_q];

   // A push into a full FIFO is dropped even when a pop happens in the same cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      do_push  = push_i & ~full_o;
      do_pop   = pop_i & ~empty_o;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
         2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // NOTE: storage is not reset; entries are only read behind a valid count.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_id_i;
   end

endmodule

// File: rtl/wbf_rd_arb.sv
// Weight-buffer read arbiter: grants one PE-row request per cycle onto the
// registered WBF address port and steers returned data back in issue order.
// rst_n is an active-high asynchronous reset despite its name.
module wbf_rd_arb
   import wca_pkg::*;
#(
   parameter int NUM_PORT       = NUM_PORT_DEF,
   parameter int WEI_ADDR_WIDTH = WEI_ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int OUTST_DEPTH    = OUTST_DEPTH_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           TOPARB_CfgVld,
   input  logic [1:0]                     TOPARB_CfgISA,
   output logic                           ARBTOP_CfgRdy,
   input  logic [NUM_PORT-1:0]            PERARB_AdrVld,
   input  logic [NUM_PORT*WEI_ADDR_WIDTH-1:0] PERARB_Adr,
   output logic [NUM_PORT-1:0]            ARBPER_AdrRdy,
   output logic [NUM_PORT-1:0]            ARBPER_DatVld,
   output logic [NUM_PORT*DATA_WIDTH-1:0] ARBPER_Dat,
   input  logic [NUM_PORT-1:0]            PERARB_DatRdy,
   output logic                           ARBWBF_AdrVld,
   output logic [WEI_ADDR_WIDTH-1:0]      ARBWBF_Adr,
   input  logic                           WBFARB_AdrRdy,
   input  logic                           WBFARB_DatVld,
   input  logic [DATA_WIDTH-1:0]          WBFARB_Dat,
   output logic                           ARBWBF_DatRdy,
   output logic                           ARBTOP_Err
);

   localparam int ID_W  = id_width(NUM_PORT);
   localparam int CNT_W = $clog2(OUTST_DEPTH) + 1;

   logic [1:0]                mode_q, mode_d;
   logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
   logic                      adr_vld_q, adr_vld_d;
   logic [WEI_ADDR_WIDTH-1:0] adr_q, adr_d;
   logic                      err_q, err_d;

   logic [ID_W-1:0]  win, cand, head_id;
   logic             any_req, load, accept, pop, cfg_rdy;
   logic             fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_cnt;

   // Scanning downwards leaves the lowest index (or offset from rr_ptr) as the winner.
   always_comb begin
      win     = '0;
      cand    = '0;
      any_req = |PERARB_AdrVld;
      if (mode_q == ARB_MODE_FIXED) begin
         for (int i = NUM_PORT - 1; i >= 0; i--)
            if (PERARB_AdrVld[i]) win = ID_W'(i);
      end else begin
         for (int k = NUM_PORT - 1; k >= 0; k--) begin
            cand = rr_ptr_q + ID_W'(k);
            if (PERARB_AdrVld[cand]) win = cand;
         end
      end
   end

   assign cfg_rdy = ~adr_vld_q & (fifo_cnt == '0);
   assign load    = (~adr_vld_q | WBFARB_AdrRdy) & ~fifo_full & (mode_q != ARB_MODE_HOLD);
   assign accept  = load & any_req;

   always_comb begin
      ARBPER_AdrRdy = '0;
      ARBPER_DatVld = '0;
      for (int i = 0; i < NUM_PORT; i++) begin
         ARBPER_AdrRdy[i] = accept & (win == ID_W'(i));
         ARBPER_DatVld[i] = WBFARB_DatVld & ~fifo_empty & (head_id == ID_W'(i));
      end
   end

   assign ARBWBF_DatRdy = PERARB_DatRdy[head_id] & ~fifo_empty;
   assign pop           = WBFARB_DatVld & ARBWBF_DatRdy;
   assign ARBPER_Dat    = {NUM_PORT{WBFARB_Dat}};

   always_comb begin
      mode_d    = mode_q;
      rr_ptr_d  = rr_ptr_q;
      adr_vld_d = adr_vld_q;
      adr_d     = adr_q;
      err_d     = err_q;
      if (TOPARB_CfgVld && cfg_rdy) mode_d = TOPARB_CfgISA;
      // The output address is held until the WBF takes it unless a new grant replaces it.
      if (accept) begin
         adr_vld_d = 1'b1;
         adr_d     = PERARB_Adr[win*WEI_ADDR_WIDTH +: WEI_ADDR_WIDTH];
         rr_ptr_d  = win + ID_W'(1);
      end else if (WBFARB_AdrRdy) begin
         adr_vld_d = 1'b0;
      end
      if (WBFARB_DatVld && fifo_empty) err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         mode_q    <= ARB_MODE_RR;
         rr_ptr_q  <= '0;
         adr_vld_q <= 1'b0;
         adr_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         rr_ptr_q  <= rr_ptr_d;
         adr_vld_q <= adr_vld_d;
         adr_q     <= adr_d;
         err_q     <= err_d;
      end
   end

   assign ARBTOP_CfgRdy = cfg_rdy;
   assign ARBWBF_AdrVld = adr_vld_q;
   assign ARBWBF_Adr    = adr_q;
   assign ARBTOP_Err    = err_q;

   arb_id_fifo #(
      .WIDTH (ID_W),
      .DEPTH (OUTST_DEPTH)
   ) u_id_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (accept),
      .push_id_i (win),
      .pop_i     (pop),
      .head_id_o (head_id),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_cnt)
   );

endmodule

// File: tb/tb_wbf_rd_arb.sv
// Bench for wbf_rd_arb: a queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations on grants, addresses and data.
module tb_wbf_rd_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_vld;
   logic [1:0]  cfg_isa;
   logic [3:0]  per_adr_vld;
   logic [31:0] per_adr;
   logic [3:0]  per_dat_rdy;
   logic        wbf_adr_rdy;
   logic        wbf_dat_vld;
   logic [7:0]  wbf_dat;

   logic        ARBTOP_CfgRdy;
   logic [3:0]  ARBPER_AdrRdy;
   logic [3:0]  ARBPER_DatVld;
   logic [31:0] ARBPER_Dat;
   logic        ARBWBF_AdrVld;
   logic [7:0]  ARBWBF_Adr;
   logic        ARBWBF_DatRdy;
   logic        ARBTOP_Err;

   always #5 clk = ~clk;

   wbf_rd_arb dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .TOPARB_CfgVld (cfg_vld),
      .TOPARB_CfgISA (cfg_isa),
      .ARBTOP_CfgRdy (ARBTOP_CfgRdy),
      .PERARB_AdrVld (per_adr_vld),
      .PERARB_Adr    (per_adr),
      .ARBPER_AdrRdy (ARBPER_AdrRdy),
      .ARBPER_DatVld (ARBPER_DatVld),
      .ARBPER_Dat    (ARBPER_Dat),
      .PERARB_DatRdy (per_dat_rdy),
      .ARBWBF_AdrVld (ARBWBF_AdrVld),
      .ARBWBF_Adr    (ARBWBF_Adr),
      .WBFARB_AdrRdy (wbf_adr_rdy),
      .WBFARB_DatVld (wbf_dat_vld),
      .WBFARB_Dat    (wbf_dat),
      .ARBWBF_DatRdy (ARBWBF_DatRdy),
      .ARBTOP_Err    (ARBTOP_Err)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   // Reference arbitration: mode 1 = lowest index, mode 2 never issues, else round robin from ptr.
   function automatic int pick(input logic [3:0] req, input int mode, input int ptr);
      if (mode == 1) begin
         for (int i = 0; i < 4; i++) if (req[i]) return i;
      end else begin
         for (int k = 0; k < 4; k++) begin
            int p;
            p = (ptr + k) % 4;
            if (req[p]) return p;
         end
      end
      return -1;
   endfunction

   // Reference model: state holds what the DUT should contain after the coming edge.
   int         m_mode, m_ptr;
   bit         m_pend, m_err;
   logic [7:0] m_adr;
   int         m_q[$];

   always @(negedge clk) begin : model
      int         n_q, win;
      bit         idle, load, acc;
      logic [3:0] e_adr_rdy, e_dvld;
      logic       e_drdy;
      if (rst_n) begin
         m_mode = 0; m_ptr = 0; m_pend = 0; m_adr = 8'h00; m_err = 0;
         m_q.delete();
      end
      n_q  = m_q.size();
      idle = !m_pend && (n_q == 0);
      load = (!m_pend || wbf_adr_rdy) && (n_q < 4) && (m_mode != 2);
      win  = pick(per_adr_vld, m_mode, m_ptr);
      acc  = load && (win >= 0);
      e_adr_rdy = acc ? 4'(1 << win) : 4'b0000;
      e_dvld = 4'b0000;
      e_drdy = 1'b0;
      if (n_q > 0) begin
         e_drdy = per_dat_rdy[m_q[0]];
         if (wbf_dat_vld) e_dvld[m_q[0]] = 1'b1;
      end
      check("adr_rdy", ARBPER_AdrRdy, e_adr_rdy);
      check("dat_vld", ARBPER_DatVld, e_dvld);
      check("wbf_dat_rdy", ARBWBF_DatRdy, e_drdy);
      check("cfg_rdy", ARBTOP_CfgRdy, idle);
      check("wbf_adr_vld", ARBWBF_AdrVld, m_pend);
      check("wbf_adr", ARBWBF_Adr, m_adr);
      check("err", ARBTOP_Err, m_err);
      check("per_dat", ARBPER_Dat, {4{wbf_dat}});
      if (!rst_n) begin
         if (wbf_dat_vld && n_q == 0) m_err = 1;
         if (wbf_dat_vld && n_q > 0 && per_dat_rdy[m_q[0]]) void'(m_q.pop_front());
         if (acc) begin
            m_q.push_back(win);
            m_pend = 1;
            m_adr  = per_adr[win*8 +: 8];
            m_ptr  = (win + 1) % 4;
         end else if (wbf_adr_rdy) begin
            m_pend = 0;
         end
         if (cfg_vld && idle) m_mode = int'(cfg_isa);
      end
   end

   // Bench-side WBF responder state and scenario logs.
   bit         ret_en, inj_dvld, auto_drop, cfg_loaded;
   int         rq[$];
   int         g_log[$], w_log[$], w_cyc[$], d_log[$], d_dat[$];
   int         cyc;
   logic [3:0] s_adr_rdy, s_dat_vld;
   logic       s_dat_rdy, s_cfg_rdy, s_err;

   task automatic step();
      bit         fired, acc;
      logic [7:0] a;
      @(negedge clk);
      cyc++;
      s_adr_rdy = ARBPER_AdrRdy;
      s_dat_vld = ARBPER_DatVld;
      s_dat_rdy = ARBWBF_DatRdy;
      s_cfg_rdy = ARBTOP_CfgRdy;
      s_err     = ARBTOP_Err;
      fired = wbf_dat_vld && ARBWBF_DatRdy;
      acc   = ARBWBF_AdrVld && wbf_adr_rdy;
      a     = ARBWBF_Adr;
      for (int i = 0; i < 4; i++) begin
         if (ARBPER_AdrRdy[i]) g_log.push_back(i);
         if (fired && ARBPER_DatVld[i]) begin
            d_log.push_back(i);
            d_dat.push_back(int'(wbf_dat));
         end
      end
      if (acc) begin
         w_log.push_back(int'(a));
         w_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      if (acc) rq.push_back(int'(a));
      if (fired && rq.size() > 0) void'(rq.pop_front());
      if (auto_drop) per_adr_vld = per_adr_vld & ~s_adr_rdy;
      if (cfg_vld && s_cfg_rdy) begin
         cfg_vld    = 1'b0;
         cfg_loaded = 1;
      end
      wbf_dat_vld = inj_dvld || (ret_en && rq.size() > 0);
      wbf_dat     = 8'h00;
      if (rq.size() > 0) wbf_dat = 8'(rq[0]) ^ 8'h5A;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_logs();
      g_log.delete(); w_log.delete(); w_cyc.delete(); d_log.delete(); d_dat.delete();
   endtask

   task automatic configure(input logic [1:0] isa);
      cfg_loaded = 0;
      cfg_vld    = 1'b1;
      cfg_isa    = isa;
      step();
      check("cfg_loaded", cfg_loaded, 1);
   endtask

   initial begin
      int stall;
      rst_n = 1'b1; cfg_vld = 1'b0; cfg_isa = 2'b00;
      per_adr_vld = 4'b0000; per_adr = {8'h13, 8'h12, 8'h11, 8'h10};
      per_dat_rdy = 4'b1111; wbf_adr_rdy = 1'b0; wbf_dat_vld = 1'b0; wbf_dat = 8'h00;
      ret_en = 0; inj_dvld = 0; auto_drop = 0; cfg_loaded = 0; cyc = 0;
      steps(3);
      check("rst_cfg_rdy", s_cfg_rdy, 1'b1);
      check("rst_err", s_err, 1'b0);
      rst_n = 1'b0;
      step();

      // 1: four ports, one address each, issued 0x10..0x13 back to back
      clear_logs();
      wbf_adr_rdy = 1'b1; ret_en = 1; auto_drop = 1; per_adr_vld = 4'b1111;
      steps(10);
      check("t1_n_wbf", w_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check("t1_wbf_adr", qget(w_log, i), 32'h10 + i);
         check("t1_ret_port", qget(d_log, i), i);
         check("t1_ret_dat", qget(d_dat, i), (32'h10 + i) ^ 32'h5A);
      end
      check("t1_consecutive", qget(w_cyc, 3) - qget(w_cyc, 0), 3);

      // 2: round robin between ports 0 and 2
      clear_logs();
      auto_drop = 0; per_adr_vld = 4'b0101;
      steps(8);
      per_adr_vld = 4'b0000;
      steps(6);
      check("t2_n_grant", g_log.size(), 8);
      for (int i = 0; i < 8; i++) check("t2_grant", qget(g_log, i), (i % 2) * 2);

      // 3: fixed priority, port 1 beats port 3 until it drops
      configure(2'b01);
      clear_logs();
      per_adr_vld = 4'b1010;
      steps(4);
      per_adr_vld = 4'b1000;
      steps(2);
      per_adr_vld = 4'b0000;
      steps(6);
      check("t3_n_grant", g_log.size(), 6);
      for (int i = 0; i < 6; i++) check("t3_grant", qget(g_log, i), (i < 4) ? 1 : 3);

      // 4: FIFO full stalls issue; one return frees one slot the following cycle
      configure(2'b00);
      clear_logs();
      ret_en = 0; per_adr_vld = 4'b1111;
      stall = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (s_adr_rdy == 4'b0000) stall++;
      end
      check("t4_n_grant", g_log.size(), 4);
      check("t4_stall_ge5", stall >= 5, 1);
      ret_en = 1;
      step();
      ret_en = 0;
      step();
      check("t4_no_bypass", s_adr_rdy, 4'b0000);
      step();
      check("t4_resume", s_adr_rdy, 4'b0001);
      per_adr_vld = 4'b0000; ret_en = 1;
      steps(10);

      // 5: head port not ready holds the data and nothing leaks to other ports
      clear_logs();
      auto_drop = 1; per_dat_rdy = 4'b1011; per_adr_vld = 4'b0100;
      steps(2);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t5_dat_rdy", s_dat_rdy, 1'b0);
         check("t5_dat_vld", s_dat_vld, 4'b0100);
      end
      per_dat_rdy = 4'b1111;
      steps(3);
      check("t5_ret_port", qget(d_log, 0), 2);
      check("t5_ret_dat", qget(d_dat, 0), 32'h12 ^ 32'h5A);

      // 6: data with empty FIFO sets a sticky error; config waits for drain
      inj_dvld = 1;
      step();
      inj_dvld = 0;
      step();
      check("t6_err_dat_vld", s_dat_vld, 4'b0000);
      check("t6_err_dat_rdy", s_dat_rdy, 1'b0);
      step();
      check("t6_err_set", s_err, 1'b1);
      steps(3);
      check("t6_err_sticky", s_err, 1'b1);
      ret_en = 0; wbf_adr_rdy = 1'b0; per_adr_vld = 4'b0011;
      step();
      cfg_loaded = 0; cfg_vld = 1'b1; cfg_isa = 2'b10;
      step();
      check("t6_cfg_busy", s_cfg_rdy, 1'b0);
      wbf_adr_rdy = 1'b1;
      steps(2);
      check("t6_cfg_held", cfg_loaded, 0);
      ret_en = 1;
      for (int i = 0; i < 20 && !cfg_loaded; i++) step();
      check("t6_cfg_after_drain", cfg_loaded, 1);
      clear_logs();
      auto_drop = 0; per_adr_vld = 4'b1000;
      steps(4);
      check("t6_hold_no_grant", g_log.size(), 0);
      per_adr_vld = 4'b0000;
      steps(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
